io_input: RTL



---
 rtl/io_pkg.sv | 16 +
 rtl/io_input_key_debounce.sv | 52 +++++
 rtl/io_input.sv | 139 +++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared state encoding and decimal constants for the user-input
// block and the seven-segment display block.
package io_pkg;

  // Input-block controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    VALID   = 2'd2
  } state_e;

  // Largest legal BCD digit and the radix used by the converter.
  localparam int BCD_DIGIT_MAX = 9;
  localparam int DEC_BASE      = 10;

endpackage

// File: rtl/io_input_key_debounce.sv
// key_debounce: 2-flop synchroniser, stability counter and a one-cycle
// pulse on the debounced press (1 -> 0) edge of an active-low key.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_prev_q;
  logic [CW-1:0] cnt_q;

  // Bring the bouncing key into the clk domain; idle level is released (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Count how long the synchronised level has disagreed with the debounced
  // level; adopt it only after it held for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      deb_q      <= 1'b1;
      deb_prev_q <= 1'b1;
    end else begin
      deb_prev_q <= deb_q;
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q <= '0;
        deb_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Press only; the release edge produces nothing.
  assign press_o = deb_prev_q & ~deb_q;

endmodule

// File: rtl/io_input.sv
// io_input: reads packed BCD from switches on a debounced ENTER press,
// converts it to binary one digit per cycle (MS digit first) and offers it
// to the processor through a valid/ack handshake.
// Optional: define IO_INPUT_SIGNED_EN to add sw_sign, which negates the
// result (two's complement) when set at capture and no digit was invalid.
module io_input
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_DIGITS      = 4,
  parameter int DATA_W          = 32
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef IO_INPUT_SIGNED_EN
  input  logic                    sw_sign,
`endif
  input  logic [4*NUM_DIGITS-1:0] SW,
  input  logic                    KEY_enter,
  input  logic                    in_ack,
  output logic                    in_valid,
  output logic [DATA_W-1:0]       in_data,
  output logic                    bcd_err,
  output logic                    busy
);

  localparam int SW_W  = 4 * NUM_DIGITS;
  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_e              state_q;
  logic [SW_W-1:0]     sr_q;
  logic [DATA_W-1:0]   acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                valid_q, busy_q, err_q;
  logic [DATA_W-1:0]   data_q;
  logic                press;
  logic                sign_q;

  logic [3:0]          digit;
  logic [DATA_W-1:0]   acc_d;
  logic                err_d;
  logic [DATA_W-1:0]   result_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk    (clk),
    .rst_n  (reset),
    .key_n_i(KEY_enter),
    .press_o(press)
  );

`ifdef IO_INPUT_SIGNED_EN
  logic sign_s1_q, sign_s2_q;

  // Synchronise the sign switch like the key; it is sampled only on press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sign_s1_q <= 1'b0;
      sign_s2_q <= 1'b0;
    end else begin
      sign_s1_q <= sw_sign;
      sign_s2_q <= sign_s1_q;
    end
  end
`endif

  // Next accumulator value, error flag and the value to publish after the
  // last digit; the invalid digit check includes the digit being consumed.
  always_comb begin
    digit    = sr_q[SW_W-1 -: 4];
    acc_d    = acc_q * DATA_W'(DEC_BASE) + DATA_W'(digit);
    err_d    = err_q | (digit > 4'(BCD_DIGIT_MAX));
    result_d = acc_d;
    if (err_d) begin
      result_d = '0;
    end else if (sign_q) begin
      result_d = ~acc_d + DATA_W'(1);
    end
  end

  // Controller: capture on press, one digit per cycle, hold until acked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      sign_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press) begin
            sr_q    <= SW;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CONVERT;
`ifdef IO_INPUT_SIGNED_EN
            sign_q  <= sign_s2_q;
`else
            sign_q  <= 1'b0;
`endif
          end
        end
        CONVERT: begin
          acc_q <= acc_d;
          sr_q  <= sr_q << 4;
          cnt_q <= cnt_q + 1'b1;
          err_q <= err_d;
          if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            data_q  <= result_d;
            state_q <= VALID;
          end
        end
        VALID: begin
          if (in_ack) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_valid = valid_q;
  assign in_data  = data_q;
  assign bcd_err  = err_q;
  assign busy     = busy_q;

endmodule
